// File: rtl/posit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pkg (package)
//  Description : Shared helpers for the posit encoder back-end.
//                - bs_width / sw_width : regime-count and signed-scale widths
//                - nar / maxpos / minpos : posit special patterns for width n,
//                  returned in a MAX_N-bit container (slice [n-1:0] to use)
//                - s1_flags_t : per-beat control flags carried by stage 1
//  Revision    : 1.0  initial release
// ============================================================================
package posit_pkg;

  // Widest posit the constant helpers can describe.
  localparam int MAX_N = 64;

  function automatic int bs_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int sw_width(input int n, input int es);
    return es + $clog2(n) + 2;
  endfunction

  // Not-a-Real: only the sign bit set.
  function automatic logic [MAX_N-1:0] nar(input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i == n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Largest positive posit: every bit below the sign set.
  function automatic logic [MAX_N-1:0] maxpos(input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n - 1) r[i] = 1'b1;
    end
    return r;
  endfunction

  // Smallest positive posit.
  function automatic logic [MAX_N-1:0] minpos(input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    if (n > 1) r[0] = 1'b1;
    return r;
  endfunction

  // Control flags travelling with a beat through stage 1.
  typedef struct packed {
    logic sign;
    logic sticky;
    logic zero;
    logic inf;
    logic sat_max;
    logic sat_min;
  } s1_flags_t;

endpackage
`default_nettype wire

// File: rtl/posit_round_ne.sv
`default_nettype none
// ============================================================================
//  Module      : posit_round_ne
//  Description : Combinational round-to-nearest-even of a posit magnitude
//                with saturation. The result is never 0 and never spills into
//                the sign position, so it always encodes a finite non-zero
//                posit.
//  Ports       : i_mag      MW  truncated magnitude (bits below the sign)
//                i_guard    1   first discarded bit
//                i_sticky   1   OR of all further discarded bits
//                i_sat_max  1   force maxpos magnitude
//                i_sat_min  1   force minpos magnitude
//                o_mag      MW  rounded, saturated magnitude
//  Revision    : 1.0  initial release
// ============================================================================
module posit_round_ne #(
  parameter int MW = 32
) (
  input  logic [MW-1:0] i_mag,
  input  logic          i_guard,
  input  logic          i_sticky,
  input  logic          i_sat_max,
  input  logic          i_sat_min,
  output logic [MW-1:0] o_mag
);

  logic          w_up;
  logic [MW:0]   w_sum;

  // Ties (guard set, nothing below) go to the even neighbour.
  assign w_up  = i_guard && (i_sticky || i_mag[0]);
  assign w_sum = {1'b0, i_mag} + {{MW{1'b0}}, w_up};

  always_comb begin
    o_mag = w_sum[MW-1:0];
    if (i_sat_max || w_sum[MW]) begin
      o_mag = {MW{1'b1}};
    end else if (i_sat_min || (w_sum == '0)) begin
      o_mag = {{(MW-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: rtl/posit_pack.sv
`default_nettype none
// ============================================================================
//  Module      : posit_pack
//  Description : Two-stage pipelined posit encoder. Packs a normalized
//                (sign, scale, mantissa) triple into an N-bit posit with
//                round-to-nearest-even and saturation to maxpos/minpos.
//                Stage 1 builds the regime, stage 2 aligns, rounds and
//                negates. Valid/ready on both sides, one beat per cycle.
//  Ports       : clk, rst_n            clock / async active-low reset
//                in_valid/in_ready     input handshake
//                in_sign, in_scale     sign, signed scale k*2^ES+e (SW bits)
//                in_frac               mantissa 1.xxx, hidden bit at MSB
//                in_sticky             OR of upstream discarded bits
//                in_zero, in_inf       exact zero / NaR request
//                out_valid/out_ready   output handshake
//                out_posit             encoded posit
//                out_zero, out_inf     out_posit is zero / NaR
//  Revision    : 1.0  initial release (N <= 64)
// ============================================================================
module posit_pack
  import posit_pkg::*;
#(
  parameter  int N  = 33,
  parameter  int ES = 5,
  parameter  int FW = N,
  localparam int SW = sw_width(N, ES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_inf,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic          out_zero,
  output logic          out_inf
);

  localparam int BS = bs_width(N);
  localparam int KW = BS + 2;            // width of k = scale >>> ES
  localparam int RW = $clog2(N + 1);     // holds a regime length up to N
  localparam int TW = ES + FW - 1;       // exponent + fraction without hidden bit
  localparam int UW = N + TW;            // alignment window, nothing lost off the end

  localparam logic [MAX_N-1:0] C_NAR_W = nar(N);
  localparam logic [N-1:0]     c_nar   = C_NAR_W[N-1:0];
  localparam logic [KW-1:0]    c_kmax  = KW'(N - 2);
  localparam logic [KW-1:0]    c_kmin  = KW'(-(N - 2));

  typedef struct packed {
    logic [RW-1:0] rlen;
    logic [N-1:0]  regime;   // left-aligned regime pattern
    logic [ES-1:0] exp;
    logic [FW-2:0] frac;
    s1_flags_t     flags;
  } s1_t;

  // ---------------------------------------------------------------- handshake
  logic w_s2_ready;
  logic r_s1_valid;

  assign w_s2_ready = !out_valid || out_ready;
  assign in_ready   = !r_s1_valid || w_s2_ready;

  // ---------------------------------------------------------- stage 1 (comb)
  logic [KW-1:0] w_k;
  logic          w_k_neg;
  logic [KW:0]   w_rlen_wide;
  logic [KW-1:0] w_sh;
  s1_t           w_s1;
  s1_t           r_s1;
  logic          w_unused_hidden;

  // Arithmetic shift right by ES is exactly the upper scale bits.
  assign w_k             = in_scale[SW-1:ES];
  assign w_k_neg         = w_k[KW-1];
  assign w_unused_hidden = in_frac[FW-1];

  always_comb begin
    if (!w_k_neg) begin
      w_rlen_wide = {1'b0, w_k} + (KW+1)'(2);
      w_sh        = w_k + KW'(1);
    end else begin
      w_rlen_wide = (KW+1)'(1) - {w_k[KW-1], w_k};
      w_sh        = KW'(0) - w_k;
    end

    w_s1               = '0;
    w_s1.rlen          = RW'(w_rlen_wide);
    // k >= 0: (k+1) ones then a zero; k < 0: (-k) zeros then a one.
    w_s1.regime        = w_k_neg ? ({1'b1, {(N-1){1'b0}}} >> w_sh)
                                 : ~({N{1'b1}} >> w_sh);
    w_s1.exp           = in_scale[ES-1:0];
    w_s1.frac          = in_frac[FW-2:0];
    w_s1.flags.sign    = in_sign;
    w_s1.flags.sticky  = in_sticky;
    w_s1.flags.zero    = in_zero;
    w_s1.flags.inf     = in_inf;
    w_s1.flags.sat_max = $signed(w_k) > $signed(c_kmax);
    w_s1.flags.sat_min = $signed(w_k) < $signed(c_kmin);
  end

  // ------------------------------------------------------ stage 1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      r_s1 <= w_s1;
    end
  end

  // ---------------------------------------------------------- stage 2 (comb)
  logic [UW-1:0] w_u;
  logic [N-2:0]  w_mag_trunc;
  logic          w_guard;
  logic          w_sx;
  logic [N-2:0]  w_mag;
  logic [N-1:0]  w_pos;
  logic [N-1:0]  w_posit;

  // Regime at the top, exponent+fraction packed right behind it.
  assign w_u = {r_s1.regime, {(UW-N){1'b0}}}
             | ({r_s1.exp, r_s1.frac, {(UW-TW){1'b0}}} >> r_s1.rlen);

  assign w_mag_trunc = w_u[UW-1 -: N-1];
  assign w_guard     = w_u[UW-N];
  assign w_sx        = (|w_u[UW-N-1:0]) | r_s1.flags.sticky;

  posit_round_ne #(
    .MW (N-1)
  ) u_round (
    .i_mag     (w_mag_trunc),
    .i_guard   (w_guard),
    .i_sticky  (w_sx),
    .i_sat_max (r_s1.flags.sat_max),
    .i_sat_min (r_s1.flags.sat_min),
    .o_mag     (w_mag)
  );

  assign w_pos = {1'b0, w_mag};

  always_comb begin
    w_posit = r_s1.flags.sign ? (~w_pos + N'(1)) : w_pos;
    if (r_s1.flags.inf) begin
      w_posit = c_nar;
    end else if (r_s1.flags.zero) begin
      w_posit = '0;
    end
  end

  // ------------------------------------------------------ stage 2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_posit <= '0;
      out_zero  <= 1'b0;
      out_inf   <= 1'b0;
    end else if (w_s2_ready) begin
      out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        out_posit <= w_posit;
        out_zero  <= r_s1.flags.zero && !r_s1.flags.inf;
        out_inf   <= r_s1.flags.inf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_posit_pack.sv
`default_nettype none
// ============================================================================
//  Module      : tb_posit_pack
//  Description : Self-checking bench for posit_pack at N=16, ES=1, FW=16.
//                Directed vector table plus a streaming sequence with
//                output back-pressure and a mid-stream reset.
//                Scale inputs are 7 bits wide at this size, so saturation
//                cases use the extreme representable scales (63 / -64).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_posit_pack;

  localparam int N  = 16;
  localparam int ES = 1;
  localparam int FW = 16;
  localparam int SW = 7;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [SW-1:0] in_scale;
  logic [FW-1:0] in_frac;
  logic          in_sticky;
  logic          in_zero;
  logic          in_inf;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_posit;
  logic          out_zero;
  logic          out_inf;

  int errors = 0;
  int checks = 0;

  posit_pack #(
    .N  (N),
    .ES (ES),
    .FW (FW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_scale  (in_scale),
    .in_frac   (in_frac),
    .in_sticky (in_sticky),
    .in_zero   (in_zero),
    .in_inf    (in_inf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit),
    .out_zero  (out_zero),
    .out_inf   (out_inf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          sign;
    logic [SW-1:0] scale;
    logic [FW-1:0] frac;
    logic          sticky;
    logic          zero;
    logic          inf;
    logic [N-1:0]  posit;
    logic          ezero;
    logic          einf;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [SW-1:0] sc, input logic [FW-1:0] f,
                              input logic st, input logic z, input logic i,
                              input logic [N-1:0] p, input logic ez, input logic ei);
    vec_t v;
    v.sign = s; v.scale = sc; v.frac = f; v.sticky = st; v.zero = z; v.inf = i;
    v.posit = p; v.ezero = ez; v.einf = ei;
    return v;
  endfunction

  vec_t vecs[$];

  // Expected encodings for scale 0..7, mantissa 1.0, ES=1.
  logic [N-1:0] stream_exp [8];

  initial begin
    //           sign scale  frac      st z  i  posit     ez ei
    vecs.push_back(mk(0, 7'h00, 16'h8000, 0, 0, 0, 16'h4000, 0, 0)); // 1.0
    vecs.push_back(mk(1, 7'h00, 16'h8000, 0, 0, 0, 16'hC000, 0, 0)); // -1.0
    vecs.push_back(mk(0, 7'h01, 16'hC000, 0, 0, 0, 16'h5800, 0, 0)); // 3.0
    vecs.push_back(mk(0, 7'h7F, 16'h8000, 0, 0, 0, 16'h3000, 0, 0)); // 0.5
    vecs.push_back(mk(0, 7'h3F, 16'h8000, 0, 0, 0, 16'h7FFF, 0, 0)); // sat max
    vecs.push_back(mk(0, 7'h40, 16'h8000, 0, 0, 0, 16'h0001, 0, 0)); // sat min
    vecs.push_back(mk(1, 7'h3F, 16'h8000, 0, 0, 0, 16'h8001, 0, 0)); // -maxpos
    vecs.push_back(mk(0, 7'h00, 16'h8004, 0, 0, 0, 16'h4000, 0, 0)); // tie, even stays
    vecs.push_back(mk(0, 7'h00, 16'h8004, 1, 0, 0, 16'h4001, 0, 0)); // tie broken by sticky
    vecs.push_back(mk(0, 7'h00, 16'h800C, 0, 0, 0, 16'h4002, 0, 0)); // tie, odd rounds up
    vecs.push_back(mk(0, 7'h00, 16'h8000, 0, 1, 1, 16'h8000, 0, 1)); // inf beats zero
    vecs.push_back(mk(1, 7'h05, 16'h8000, 0, 1, 0, 16'h0000, 1, 0)); // zero, sign ignored
    vecs.push_back(mk(0, 7'h1C, 16'h8000, 0, 0, 0, 16'h7FFF, 0, 0)); // k=14, exact maxpos
    vecs.push_back(mk(0, 7'h1E, 16'h8000, 0, 0, 0, 16'h7FFF, 0, 0)); // k=15 saturates
    vecs.push_back(mk(0, 7'h64, 16'h8000, 0, 0, 0, 16'h0001, 0, 0)); // k=-14, exact minpos
    vecs.push_back(mk(0, 7'h65, 16'h8000, 0, 0, 0, 16'h0002, 0, 0)); // k=-14 e=1 rounds up
    vecs.push_back(mk(0, 7'h63, 16'h8000, 0, 0, 0, 16'h0001, 0, 0)); // k=-15 saturates
    vecs.push_back(mk(0, 7'h02, 16'hA000, 0, 0, 0, 16'h6200, 0, 0)); // 5.0
    vecs.push_back(mk(1, 7'h02, 16'hA000, 0, 0, 0, 16'h9E00, 0, 0)); // -5.0
    vecs.push_back(mk(0, 7'h01, 16'hC000, 1, 0, 0, 16'h5800, 0, 0)); // sticky alone no round

    stream_exp[0] = 16'h4000; stream_exp[1] = 16'h5000;
    stream_exp[2] = 16'h6000; stream_exp[3] = 16'h6800;
    stream_exp[4] = 16'h7000; stream_exp[5] = 16'h7400;
    stream_exp[6] = 16'h7800; stream_exp[7] = 16'h7A00;

    rst_n = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_scale = '0; in_frac = '0;
    in_sticky = 1'b0; in_zero = 1'b0; in_inf = 1'b0; out_ready = 1'b1;

    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset out_posit", {16'd0, out_posit}, 32'd0);
    check("reset out_zero",  {31'd0, out_zero},  32'd0);
    check("reset out_inf",   {31'd0, out_inf},   32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready after reset", {31'd0, in_ready}, 32'd1);

    // ------------------------------------------------------ directed table
    for (int i = 0; i < vecs.size(); i++) begin
      int w;
      @(negedge clk);
      in_valid  = 1'b1;
      in_sign   = vecs[i].sign;
      in_scale  = vecs[i].scale;
      in_frac   = vecs[i].frac;
      in_sticky = vecs[i].sticky;
      in_zero   = vecs[i].zero;
      in_inf    = vecs[i].inf;
      @(negedge clk);
      in_valid = 1'b0;
      w = 0;
      while (!out_valid && w < 5) begin
        @(negedge clk);
        w++;
      end
      check($sformatf("vec%0d latency", i), w, 1);
      check($sformatf("vec%0d posit", i), {16'd0, out_posit}, {16'd0, vecs[i].posit});
      check($sformatf("vec%0d zero", i), {31'd0, out_zero}, {31'd0, vecs[i].ezero});
      check($sformatf("vec%0d inf", i), {31'd0, out_inf}, {31'd0, vecs[i].einf});
    end

    // ------------------------------ stream with back-pressure and a reset
    begin
      logic [N-1:0] expq[$];
      int  acc = 0;
      int  cyc = 0;
      int  post_out = 0;
      bit  rdy = 1'b1;
      bit  did_reset = 1'b0;
      in_sign = 1'b0; in_frac = 16'h8000; in_sticky = 1'b0; in_zero = 1'b0; in_inf = 1'b0;
      while ((acc < 8 || expq.size() > 0) && cyc < 200) begin
        @(negedge clk);
        cyc++;
        out_ready = rdy;
        rdy = !rdy;
        if (acc == 5 && !did_reset) begin
          in_valid = 1'b0;
          rst_n = 1'b0;
          #1;
          check("async reset out_valid", {31'd0, out_valid}, 32'd0);
          check("async reset out_posit", {16'd0, out_posit}, 32'd0);
          expq.delete();
          @(negedge clk);
          rst_n = 1'b1;
          #1;
          check("in_ready after mid reset", {31'd0, in_ready}, 32'd1);
          did_reset = 1'b1;
        end else begin
          in_valid = (acc < 8);
          in_scale = SW'(acc);
          #1;
          check($sformatf("stream in_ready c%0d", cyc), {31'd0, in_ready},
                {31'd0, !(expq.size() == 2 && !out_ready)});
          if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
              check("stream unexpected output", {16'd0, out_posit}, 32'hFFFF_FFFF);
            end else begin
              check($sformatf("stream out c%0d", cyc), {16'd0, out_posit}, {16'd0, expq.pop_front()});
            end
            if (did_reset) post_out++;
          end
          if (in_valid && in_ready) begin
            expq.push_back(stream_exp[acc]);
            acc++;
          end
        end
      end
      in_valid = 1'b0;
      check("stream all accepted", acc, 8);
      check("stream drained", expq.size(), 0);
      check("stream outputs after reset", post_out, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
